ov7670_stream_gen: RTL and testbench

Synthesizable OV7670-style video source: drives PCLK, VSYNC, HREF and an 8-bit RGB565 byte stream exactly as the camera presents them to the capture path (`cmos_capture_data`, `processing`). It generates test patterns with no sensor attached. It sits in place of the OV7670 pins, either in simulation or behind a top-level mux for board bring-up. It is the transmitter for the existing pixel-capture receivers.

---
 rtl/ov7670_gen_pkg.sv | 53 +++++
 rtl/ov7670_pattern_gen.sv | 33 +++
 rtl/ov7670_stream_gen.sv | 207 ++++++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_gen_pkg
//  Description : Shared types and constants for the OV7670-style test-pattern
//                stream generator: FSM state encoding, pattern_sel codes and
//                the RGB565 colour-bar palette.
//  Revision    : 1.0 - initial release
// ============================================================================
package ov7670_gen_pkg;

    // Frame sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } gen_state_e;

    // pattern_sel encodings
    localparam logic [1:0] c_PAT_BARS    = 2'd0;
    localparam logic [1:0] c_PAT_RAMP    = 2'd1;
    localparam logic [1:0] c_PAT_CHECKER = 2'd2;
    localparam logic [1:0] c_PAT_SOLID   = 2'd3;

    // Colour-bar palette, left to right
    localparam logic [15:0] c_BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] c_BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] c_BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] c_BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] c_BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] c_BAR_RED     = 16'hF800;
    localparam logic [15:0] c_BAR_BLUE    = 16'h001F;
    localparam logic [15:0] c_BAR_BLACK   = 16'h0000;

    // Bar index (0 = leftmost) to RGB565 colour
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] colour;
        case (idx)
            3'd0:    colour = c_BAR_WHITE;
            3'd1:    colour = c_BAR_YELLOW;
            3'd2:    colour = c_BAR_CYAN;
            3'd3:    colour = c_BAR_GREEN;
            3'd4:    colour = c_BAR_MAGENTA;
            3'd5:    colour = c_BAR_RED;
            3'd6:    colour = c_BAR_BLUE;
            default: colour = c_BAR_BLACK;
        endcase
        return colour;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_pattern_gen
//  Description : Combinational pixel source. Maps the active-area position,
//                the running bar index and the per-frame latched selection
//                to one RGB565 pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_pattern_gen
    import ov7670_gen_pkg::*;
(
    input  logic [1:0]  sel,      // latched pattern_sel
    input  logic [15:0] solid,    // latched solid colour
    input  logic [5:0]  x_hi,     // pixel x bits [7:2]
    input  logic        y_b3,     // line y bit 3
    input  logic [2:0]  bar_idx,  // colour-bar index for this pixel
    output logic [15:0] pixel
);

    // Pattern select; x_hi[1] is x[3], x_hi[5:1] is x[7:3]
    always_comb begin
        pixel = 16'h0000;
        case (sel)
            c_PAT_BARS:    pixel = bar_colour(bar_idx);
            c_PAT_RAMP:    pixel = {x_hi[5:1], x_hi, x_hi[5:1]};
            c_PAT_CHECKER: pixel = (x_hi[1] ^ y_b3) ? 16'hFFFF : 16'h0000;
            c_PAT_SOLID:   pixel = solid;
            default:       pixel = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_stream_gen
//  Description : OV7670-style video source. Produces pclk (clk/2), vsync,
//                href and an RGB565 byte stream carrying test patterns.
//                Every output except pclk and frame_start changes only on
//                the clk edge where pclk falls, so all are stable at the
//                pclk rising edge used by the capture side.
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_stream_gen
    import ov7670_gen_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    // Slot counter is kept at least 9 bits so pixel x[7:2] = slot[8:3] is
    // always addressable; line counter at least 4 bits for y[3].
    localparam int LINE_SLOTS = 2 * (H_ACTIVE + H_BLANK);
    localparam int SLOT_W_RAW = $clog2(LINE_SLOTS);
    localparam int SLOT_W     = (SLOT_W_RAW < 9) ? 9 : SLOT_W_RAW;
    localparam int MAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LINE_W_RAW = $clog2(MAX_LINES);
    localparam int LINE_W     = (LINE_W_RAW < 4) ? 4 : LINE_W_RAW;
    localparam int BAR_PIX    = H_ACTIVE / 8;
    localparam int BAR_W      = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

    localparam logic [SLOT_W-1:0] c_SLOT_LAST    = SLOT_W'(LINE_SLOTS - 1);
    localparam logic [SLOT_W-1:0] c_ACTIVE_SLOTS = SLOT_W'(2 * H_ACTIVE);
    localparam logic [LINE_W-1:0] c_VSYNC_LAST   = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] c_VBACK_LAST   = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] c_VACTIVE_LAST = LINE_W'(V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] c_VFRONT_LAST  = LINE_W'(V_FRONT - 1);
    localparam logic [BAR_W-1:0]  c_BAR_LAST     = BAR_W'(BAR_PIX - 1);

    logic              r_pclk;
    gen_state_e        r_state,   w_state_nx;
    logic [SLOT_W-1:0] r_slot,    w_slot_nx;
    logic [LINE_W-1:0] r_line,    w_line_nx;
    logic [2:0]        r_bar_idx, w_bar_idx_nx;
    logic [BAR_W-1:0]  r_bar_cnt, w_bar_cnt_nx;
    logic              w_frame_begin;
    logic              w_frame_done;
    logic              w_tick;
    logic [1:0]        r_sel;
    logic [15:0]       r_solid;
    logic              r_vsync, r_href, r_frame_start;
    logic [7:0]        r_d;
    logic [15:0]       r_frame_count;
    logic [15:0]       w_pixel;
    logic              w_href_nx;
    logic [7:0]        w_byte_nx;

    // A byte slot ends on the edge where pclk falls
    assign w_tick = r_pclk;

    // Free-running pixel-byte clock, held low in reset
    always_ff @(posedge clk) begin
        if (reset) r_pclk <= 1'b0;
        else       r_pclk <= ~r_pclk;
    end

    // Sequencer state and slot/line/bar counters, advanced once per slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_slot    <= '0;
            r_line    <= '0;
            r_bar_idx <= '0;
            r_bar_cnt <= '0;
        end else if (w_tick) begin
            r_state   <= w_state_nx;
            r_slot    <= w_slot_nx;
            r_line    <= w_line_nx;
            r_bar_idx <= w_bar_idx_nx;
            r_bar_cnt <= w_bar_cnt_nx;
        end
    end

    // Next-slot state: counters describe the slot about to be presented
    always_comb begin
        w_state_nx    = r_state;
        w_slot_nx     = r_slot;
        w_line_nx     = r_line;
        w_bar_idx_nx  = r_bar_idx;
        w_bar_cnt_nx  = r_bar_cnt;
        w_frame_begin = 1'b0;
        w_frame_done  = 1'b0;
        if (r_state == ST_IDLE) begin
            if (enable) begin
                w_state_nx    = ST_VSYNC;
                w_slot_nx     = '0;
                w_line_nx     = '0;
                w_bar_idx_nx  = '0;
                w_bar_cnt_nx  = '0;
                w_frame_begin = 1'b1;
            end
        end else if (r_slot == c_SLOT_LAST) begin
            w_slot_nx    = '0;
            w_bar_idx_nx = '0;
            w_bar_cnt_nx = '0;
            w_line_nx    = r_line + 1'b1;
            case (r_state)
                ST_VSYNC: if (r_line == c_VSYNC_LAST) begin
                    w_state_nx = ST_VBACK;
                    w_line_nx  = '0;
                end
                ST_VBACK: if (r_line == c_VBACK_LAST) begin
                    w_state_nx = ST_ACTIVE;
                    w_line_nx  = '0;
                end
                ST_ACTIVE: if (r_line == c_VACTIVE_LAST) begin
                    w_state_nx = ST_VFRONT;
                    w_line_nx  = '0;
                end
                ST_VFRONT: if (r_line == c_VFRONT_LAST) begin
                    w_line_nx    = '0;
                    w_frame_done = 1'b1;
                    if (enable) begin
                        w_state_nx    = ST_VSYNC;
                        w_frame_begin = 1'b1;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end else begin
            w_slot_nx = r_slot + 1'b1;
            // Leaving the low byte of an active pixel: step the bar counter
            if (r_slot[0] && (r_slot < c_ACTIVE_SLOTS)) begin
                if (r_bar_cnt == c_BAR_LAST) begin
                    w_bar_cnt_nx = '0;
                    w_bar_idx_nx = r_bar_idx + 1'b1;
                end else begin
                    w_bar_cnt_nx = r_bar_cnt + 1'b1;
                end
            end
        end
    end

    // In ACTIVE the line counter is the active line number y
    ov7670_pattern_gen u_pattern (
        .sel     (r_sel),
        .solid   (r_solid),
        .x_hi    (w_slot_nx[8:3]),
        .y_b3    (w_line_nx[3]),
        .bar_idx (w_bar_idx_nx),
        .pixel   (w_pixel)
    );

    assign w_href_nx = (w_state_nx == ST_ACTIVE) && (w_slot_nx < c_ACTIVE_SLOTS);
    assign w_byte_nx = w_slot_nx[0] ? w_pixel[7:0] : w_pixel[15:8];

    // Registered pin outputs, frame counter and per-frame pattern latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_d           <= 8'h00;
            r_frame_start <= 1'b0;
            r_frame_count <= 16'h0000;
            r_sel         <= 2'd0;
            r_solid       <= 16'h0000;
        end else begin
            r_frame_start <= w_tick & w_frame_begin;
            if (w_tick) begin
                r_vsync <= (w_state_nx == ST_VSYNC);
                r_href  <= w_href_nx;
                r_d     <= w_href_nx ? w_byte_nx : 8'h00;
                if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
                if (w_frame_begin) begin
                    r_sel   <= pattern_sel;
                    r_solid <= solid_color;
                end
            end
        end
    end

    assign pclk        = r_pclk;
    assign vsync       = r_vsync;
    assign href        = r_href;
    assign d           = r_d;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_stream_gen
//  Description : Directed self-checking bench for ov7670_stream_gen with a
//                small frame geometry (40 slots/line, 7 lines/frame) and a
//                pclk-rising-edge capture model for word reassembly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_stream_gen;

    localparam int H_ACTIVE    = 16;
    localparam int H_BLANK     = 4;
    localparam int V_ACTIVE    = 4;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int LINE_CLK    = 80;
    localparam int FRAME_CLK   = 560;
    localparam int FRAME_BYTES = 128;
    localparam int FRAME_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        pclk, vsync, href, frame_start;
    logic [7:0]  d;
    logic [15:0] frame_count;

    ov7670_stream_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .pclk        (pclk),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] bar_ref [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    function automatic logic [15:0] exp_pix(input int sel, input int x, input int y,
                                            input logic [15:0] solid);
        logic [7:0] xv;
        logic [7:0] yv;
        xv = x[7:0];
        yv = y[7:0];
        case (sel)
            0:       return bar_ref[x / 2];
            1:       return {xv[7:3], xv[7:2], xv[7:3]};
            2:       return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
            default: return solid;
        endcase
    endfunction

    // Event log sampled 1 time unit after every clk rise
    int          cyc = 0;
    int          q_vs_rise[$];
    int          q_vs_fall[$];
    int          q_hr_rise[$];
    logic [7:0]  q_bytes[$];
    logic [15:0] q_words[$];
    int          fs_n = 0;
    int          viol = 0;
    int          pclk_viol = 0;
    logic        p_vsync = 1'b0, p_href = 1'b0, p_pclk = 1'b0, p_reset = 1'b1;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (vsync && !p_vsync) q_vs_rise.push_back(cyc);
        if (!vsync && p_vsync) q_vs_fall.push_back(cyc);
        if (href && !p_href)   q_hr_rise.push_back(cyc);
        if (href && !pclk)     q_bytes.push_back(d);
        if (frame_start)       fs_n++;
        if (vsync && href)     viol++;
        if (!href && d != 8'h00) viol++;
        if (href != p_href && pclk != 1'b0) viol++;
        if (!reset && !p_reset && pclk == p_pclk) pclk_viol++;
        p_vsync = vsync;
        p_href  = href;
        p_pclk  = pclk;
        p_reset = reset;
    end

    // Capture-side model: byte pairs at pclk rise, high byte first
    logic       cap_half = 1'b0;
    logic [7:0] cap_hi = 8'h00;
    always @(posedge pclk) begin
        if (href) begin
            if (!cap_half) begin
                cap_hi   = d;
                cap_half = 1'b1;
            end else begin
                q_words.push_back({cap_hi, d});
                cap_half = 1'b0;
            end
        end else begin
            cap_half = 1'b0;
        end
    end

    task automatic clear_logs();
        q_vs_rise.delete();
        q_vs_fall.delete();
        q_hr_rise.delete();
        q_bytes.delete();
        q_words.delete();
        fs_n = 0;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("pclk_first_rise", pclk, 1);
        clear_logs();
    endtask

    task automatic wait_vsync_rises(input int n, input string tag);
        int budget;
        budget = 3000;
        while (q_vs_rise.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_vsync_reached"}, (q_vs_rise.size() >= n), 1);
    endtask

    // Start one frame, drop enable right after vsync rises, let it finish
    task automatic run_one_frame(input int sel, input logic [15:0] solid, input string tag);
        @(negedge clk);
        pattern_sel = sel[1:0];
        solid_color = solid;
        enable      = 1'b1;
        wait_vsync_rises(1, tag);
        @(negedge clk);
        enable = 1'b0;
        repeat (FRAME_CLK + 40) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int sel, input logic [15:0] solid);
        logic [15:0] px;
        check({tag, "_byte_count"}, q_bytes.size(), FRAME_BYTES);
        if (q_bytes.size() == FRAME_BYTES) begin
            for (int y = 0; y < V_ACTIVE; y++) begin
                for (int x = 0; x < H_ACTIVE; x++) begin
                    px = exp_pix(sel, x, y, solid);
                    check($sformatf("%s_y%0d_x%0d_hi", tag, y, x), q_bytes[(y*H_ACTIVE+x)*2],   px[15:8]);
                    check($sformatf("%s_y%0d_x%0d_lo", tag, y, x), q_bytes[(y*H_ACTIVE+x)*2+1], px[7:0]);
                end
            end
        end
    endtask

    task automatic check_words(input string tag, input logic [15:0] w);
        int bad;
        bad = 0;
        check({tag, "_word_count"}, q_words.size(), FRAME_WORDS);
        foreach (q_words[i]) if (q_words[i] !== w) bad++;
        check({tag, "_word_mismatches"}, bad, 0);
    endtask

    initial begin
        int en_cyc;
        int lat;
        int budget;

        // Reset and idle
        repeat (5) @(negedge clk);
        check("rst_pclk", pclk, 0);
        check("rst_vsync", vsync, 0);
        check("rst_href", href, 0);
        check("rst_d", d, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_count", frame_count, 0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("pclk_first_rise", pclk, 1);
        clear_logs();
        repeat (1000) @(negedge clk);
        check("idle_no_vsync", q_vs_rise.size(), 0);
        check("idle_no_href", q_hr_rise.size(), 0);
        check("idle_no_frame_start", fs_n, 0);
        check("idle_pclk_period2", pclk_viol, 0);
        check("idle_frame_count", frame_count, 0);

        // Colour bars, single frame
        @(negedge clk);
        pattern_sel = 2'd0;
        enable      = 1'b1;
        en_cyc      = cyc;
        wait_vsync_rises(1, "bars");
        lat = (q_vs_rise.size() > 0) ? q_vs_rise[0] - en_cyc : 99;
        check("start_latency_le2", (lat >= 1 && lat <= 2), 1);
        @(negedge clk);
        enable = 1'b0;
        repeat (FRAME_CLK + 40) @(negedge clk);
        check("bars_vsync_fall_seen", q_vs_fall.size(), 1);
        if (q_vs_fall.size() == 1 && q_vs_rise.size() == 1)
            check("bars_vsync_width", q_vs_fall[0] - q_vs_rise[0], LINE_CLK);
        check("bars_href_lines", q_hr_rise.size(), V_ACTIVE);
        if (q_hr_rise.size() > 0 && q_vs_rise.size() > 0)
            check("bars_first_href_delay", q_hr_rise[0] - q_vs_rise[0], 2 * LINE_CLK);
        check("bars_vsync_once", q_vs_rise.size(), 1);
        check("bars_frame_start_once", fs_n, 1);
        check("bars_frame_count", frame_count, 1);
        check_frame("bars", 0, 16'h0000);

        // Back-to-back frames
        apply_reset(3);
        @(negedge clk);
        pattern_sel = 2'd0;
        enable      = 1'b1;
        wait_vsync_rises(3, "b2b");
        @(negedge clk);
        enable = 1'b0;
        repeat (FRAME_CLK + 40) @(negedge clk);
        check("b2b_vsync_rises", q_vs_rise.size(), 3);
        if (q_vs_rise.size() == 3) begin
            check("b2b_period_1", q_vs_rise[1] - q_vs_rise[0], FRAME_CLK);
            check("b2b_period_2", q_vs_rise[2] - q_vs_rise[1], FRAME_CLK);
        end
        check("b2b_frame_start", fs_n, 3);
        check("b2b_frame_count", frame_count, 3);

        // Checkerboard, then ramp
        apply_reset(2);
        run_one_frame(2, 16'h0000, "chk");
        check_frame("chk", 2, 16'h0000);
        check("chk_frame_count", frame_count, 1);
        clear_logs();
        run_one_frame(1, 16'h0000, "ramp");
        check_frame("ramp", 1, 16'h0000);
        check("ramp_frame_count", frame_count, 2);

        // Solid with mid-frame selection change and enable drop
        clear_logs();
        @(negedge clk);
        pattern_sel = 2'd3;
        solid_color = 16'h1234;
        enable      = 1'b1;
        wait_vsync_rises(1, "solid");
        budget = 1000;
        while (q_hr_rise.size() < 1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("solid_href_reached", (q_hr_rise.size() >= 1), 1);
        @(negedge clk);
        pattern_sel = 2'd0;
        solid_color = 16'hFFFF;
        enable      = 1'b0;
        repeat (FRAME_CLK + 600) @(negedge clk);
        check_frame("solid", 3, 16'h1234);
        check_words("solid", 16'h1234);
        check("solid_frame_count", frame_count, 3);
        check("solid_back_to_idle", q_vs_rise.size(), 1);

        // Reset during active line 2, then a clean restart
        apply_reset(2);
        @(negedge clk);
        pattern_sel = 2'd3;
        solid_color = 16'h1234;
        enable      = 1'b1;
        budget = 3000;
        while (q_bytes.size() < 2 * 32 + 6 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("mrst_line2_reached", (q_bytes.size() >= 2 * 32 + 6), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("mrst_pclk", pclk, 0);
        check("mrst_vsync", vsync, 0);
        check("mrst_href", href, 0);
        check("mrst_d", d, 0);
        check("mrst_frame_start", frame_start, 0);
        check("mrst_frame_count", frame_count, 0);
        repeat (3) @(negedge clk);
        clear_logs();
        reset = 1'b0;
        wait_vsync_rises(1, "restart");
        @(negedge clk);
        enable = 1'b0;
        repeat (FRAME_CLK + 40) @(negedge clk);
        check_frame("restart", 3, 16'h1234);
        check_words("restart", 16'h1234);
        check("restart_href_lines", q_hr_rise.size(), V_ACTIVE);
        check("restart_frame_count", frame_count, 1);

        // Protocol invariants over the whole run
        check("vsync_href_excl_and_d_zero_and_href_on_fall", viol, 0);
        check("pclk_toggles_every_clk", pclk_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
